// File: rtl/hamming_pkg.sv
// Shared helpers for the streaming Hamming decoder: code geometry, data-position map, flag type.
// HAMMING_SECDED_EN adds the overall-parity bit (SECDED) and widens the input by one bit.
package hamming_pkg;

`ifdef HAMMING_SECDED_EN
    localparam bit SECDED = 1'b1;
`else
    localparam bit SECDED = 1'b0;
`endif

    typedef struct packed {
        logic corrigido;
        logic duplo;
    } flags_t;

    function automatic int n_of(input int r);
        return (1 << r) - 1;
    endfunction

    function automatic int k_of(input int r);
        return n_of(r) - r;
    endfunction

    function automatic int in_w_of(input int r);
        return n_of(r) + (SECDED ? 1 : 0);
    endfunction

    function automatic bit is_pow2(input int pos);
        return (pos > 0) && ((pos & (pos - 1)) == 0);
    endfunction

    // 1-based code position carrying data bit j (non-power-of-two positions, ascending)
    function automatic int data_pos(input int r, input int j);
        int n;
        int cnt;
        int res;
        n   = n_of(r);
        cnt = 0;
        res = 0;
        for (int p = 1; p <= n; p++) begin
            if (!is_pow2(p)) begin
                if (cnt == j) res = p;
                cnt++;
            end
        end
        return res;
    endfunction

    // Bit p-1 set when code position p contributes to syndrome bit b
    function automatic logic [63:0] syn_mask(input int r, input int b);
        logic [63:0] m;
        m = '0;
        for (int p = 1; p <= n_of(r); p++) begin
            if (((p >> b) & 1) == 1) m = m | (64'd1 << (p - 1));
        end
        return m;
    endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// Combinational syndrome generator; with HAMMING_SECDED_EN it also returns the overall parity.
module hamming_syndrome
    import hamming_pkg::*;
#(
    parameter int R = 4
) (
    input  logic [in_w_of(R)-1:0] word,
    output logic [R-1:0]          syndrome
`ifdef HAMMING_SECDED_EN
    ,
    output logic                  parity
`endif
);

    localparam int N = n_of(R);

    genvar gi;
    generate
        for (gi = 0; gi < R; gi++) begin : g_syn
            localparam logic [63:0] MASK = syn_mask(R, gi);
            assign syndrome[gi] = ^(word[N-1:0] & MASK[N-1:0]);
        end
    endgenerate

`ifdef HAMMING_SECDED_EN
    assign parity = ^word;
`endif

endmodule

// File: rtl/hamming_decoder_stream.sv
// Two-stage valid/ready Hamming decoder with single-error correction and saturating statistics.
// Define HAMMING_SECDED_EN for the SECDED variant (extra overall-parity input bit, double-error flag).
module hamming_decoder_stream
    import hamming_pkg::*;
#(
    parameter int R     = 4,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [in_w_of(R)-1:0] entrada,
    input  logic                  entrada_valid,
    output logic                  entrada_ready,
    output logic [k_of(R)-1:0]    saida,
    output logic                  saida_valid,
    input  logic                  saida_ready,
    output logic                  erro_corrigido,
    output logic                  erro_duplo,
    output logic [CNT_W-1:0]      cnt_corrigido,
    output logic [CNT_W-1:0]      cnt_duplo,
    input  logic                  cnt_clr
);

    localparam int K = k_of(R);

    logic         en1;
    logic         en2;
    logic         out_xfer;
    logic [R-1:0] syn_next;
    logic [K-1:0] data_raw;

    logic         v1_reg;
    logic [K-1:0] data1_reg;
    logic [R-1:0] syn1_reg;

    logic         v2_reg;
    logic [K-1:0] saida_reg;
    logic [K-1:0] saida_next;
    flags_t       flags_reg;
    flags_t       flags_next;
    logic         do_correct;

    logic [CNT_W-1:0] cnt_corr_reg;

    assign en2           = !v2_reg || saida_ready;
    assign en1           = !v1_reg || en2;
    assign entrada_ready = en1;
    assign out_xfer      = v2_reg && saida_ready;

`ifdef HAMMING_SECDED_EN
    logic par_next;
    logic par1_reg;

    hamming_syndrome #(.R(R)) u_syn (
        .word     (entrada),
        .syndrome (syn_next),
        .parity   (par_next)
    );
`else
    hamming_syndrome #(.R(R)) u_syn (
        .word     (entrada),
        .syndrome (syn_next)
    );
`endif

    // Only data positions are carried forward; a flip that lands on a check bit changes no output.
    genvar gi;
    generate
        for (gi = 0; gi < K; gi++) begin : g_data
            localparam int DP = data_pos(R, gi);
            localparam logic [R-1:0] DP_SYN = R'(DP);
            assign data_raw[gi]   = entrada[DP-1];
            assign saida_next[gi] = data1_reg[gi] ^ (do_correct && (syn1_reg == DP_SYN));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_reg <= 1'b0;
        end else if (en1) begin
            v1_reg <= entrada_valid;
            if (entrada_valid) begin
                data1_reg <= data_raw;
                syn1_reg  <= syn_next;
`ifdef HAMMING_SECDED_EN
                par1_reg  <= par_next;
`endif
            end
        end
    end

    always_comb begin
        flags_next = '0;
`ifdef HAMMING_SECDED_EN
        // Odd overall parity means a single error (possibly in the parity bit itself).
        do_correct           = par1_reg;
        flags_next.corrigido = par1_reg;
        flags_next.duplo     = (|syn1_reg) && !par1_reg;
`else
        do_correct           = 1'b1;
        flags_next.corrigido = |syn1_reg;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v2_reg    <= 1'b0;
            saida_reg <= '0;
            flags_reg <= '0;
        end else if (en2) begin
            v2_reg <= v1_reg;
            if (v1_reg) begin
                saida_reg <= saida_next;
                flags_reg <= flags_next;
            end
        end
    end

    assign saida          = saida_reg;
    assign saida_valid    = v2_reg;
    assign erro_corrigido = flags_reg.corrigido;
    assign erro_duplo     = flags_reg.duplo;

    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            cnt_corr_reg <= '0;
        end else if (out_xfer && flags_reg.corrigido && (cnt_corr_reg != '1)) begin
            cnt_corr_reg <= cnt_corr_reg + 1'b1;
        end
    end

    assign cnt_corrigido = cnt_corr_reg;

`ifdef HAMMING_SECDED_EN
    logic [CNT_W-1:0] cnt_dup_reg;

    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            cnt_dup_reg <= '0;
        end else if (out_xfer && flags_reg.duplo && (cnt_dup_reg != '1)) begin
            cnt_dup_reg <= cnt_dup_reg + 1'b1;
        end
    end

    assign cnt_duplo = cnt_dup_reg;
`else
    assign cnt_duplo = '0;
`endif

endmodule

// File: tb/tb_hamming_decoder_stream.sv
// Bench for hamming_decoder_stream (R=4): scoreboard of a position-arithmetic decoder model plus
// directed latency, stall, saturation and reset checks. Works with or without HAMMING_SECDED_EN.
module tb_hamming_decoder_stream;
    import hamming_pkg::*;

    localparam int R    = 4;
    localparam int N    = 15;
    localparam int K    = 11;
    localparam int IN_W = in_w_of(R);

`ifdef HAMMING_SECDED_EN
    localparam logic [IN_W-1:0] CLEAN = 16'hFFFF;
    localparam logic [IN_W-1:0] ERR_A = 16'h0020;
    localparam logic [IN_W-1:0] ERR_B = 16'hFFFE;
`else
    localparam logic [IN_W-1:0] CLEAN = 15'h7FFF;
    localparam logic [IN_W-1:0] ERR_A = 15'h0020;
    localparam logic [IN_W-1:0] ERR_B = 15'h7FFE;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [IN_W-1:0] entrada = '0;
    logic            entrada_valid = 1'b0;
    logic            saida_ready = 1'b1;
    logic            cnt_clr = 1'b0;

    logic            entrada_ready, saida_valid, erro_corrigido, erro_duplo;
    logic [K-1:0]    saida;
    logic [15:0]     cnt_corrigido, cnt_duplo;

    logic            entrada_ready_b, saida_valid_b, erro_corrigido_b, erro_duplo_b;
    logic [K-1:0]    saida_b;
    logic [1:0]      cnt_corrigido_b, cnt_duplo_b;

    hamming_decoder_stream #(.R(R), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .entrada(entrada), .entrada_valid(entrada_valid),
        .entrada_ready(entrada_ready), .saida(saida), .saida_valid(saida_valid),
        .saida_ready(saida_ready), .erro_corrigido(erro_corrigido), .erro_duplo(erro_duplo),
        .cnt_corrigido(cnt_corrigido), .cnt_duplo(cnt_duplo), .cnt_clr(cnt_clr)
    );

    hamming_decoder_stream #(.R(R), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .entrada(entrada), .entrada_valid(entrada_valid),
        .entrada_ready(entrada_ready_b), .saida(saida_b), .saida_valid(saida_valid_b),
        .saida_ready(saida_ready), .erro_corrigido(erro_corrigido_b), .erro_duplo(erro_duplo_b),
        .cnt_corrigido(cnt_corrigido_b), .cnt_duplo(cnt_duplo_b), .cnt_clr(cnt_clr)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Syndrome = XOR of the positions of all set bits; flip that position; keep non-power-of-two positions.
    function automatic void model(input logic [IN_W-1:0] w, output logic [K-1:0] d,
                                  output logic c, output logic du);
        int s;
        int j;
        logic [N-1:0] f;
        logic p;
        s = 0;
        for (int pos = 1; pos <= N; pos++) if (w[pos-1]) s = s ^ pos;
        p = ^w;
        f = w[N-1:0];
        if (SECDED) begin
            c  = p;
            du = (s != 0) && !p;
            if (s != 0 && p) f[s-1] = ~f[s-1];
        end else begin
            c  = (s != 0);
            du = 1'b0;
            if (s != 0) f[s-1] = ~f[s-1];
        end
        d = '0;
        j = 0;
        for (int pos = 1; pos <= N; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                d[j] = f[pos-1];
                j++;
            end
        end
    endfunction

    typedef struct {
        logic [K-1:0] d;
        logic         c;
        logic         du;
    } exp_t;

    exp_t q[$];
    int   cnt_c = 0;
    int   cnt_d = 0;
    bit   mon_en = 1'b0;

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    // Compare process: runs on the falling edge, then applies what the next rising edge will do.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            chk("cnt_corrigido", cnt_corrigido, sat(cnt_c, 65535));
            chk("cnt_duplo", cnt_duplo, sat(cnt_d, 65535));
            chk("cnt_corrigido_w2", cnt_corrigido_b, sat(cnt_c, 3));
            chk("cnt_duplo_w2", cnt_duplo_b, sat(cnt_d, 3));
            chk("entrada_ready", entrada_ready, (q.size() < 2) || saida_ready);
            chk("saida_valid_w2", saida_valid_b, saida_valid);
            if (saida_valid) begin
                if (q.size() == 0) begin
                    chk("spurious_output", 1, 0);
                end else begin
                    chk("saida", saida, q[0].d);
                    chk("erro_corrigido", erro_corrigido, q[0].c);
                    chk("erro_duplo", erro_duplo, q[0].du);
                    chk("saida_w2", saida_b, q[0].d);
                end
            end
            if (rst) begin
                q.delete();
                cnt_c = 0;
                cnt_d = 0;
            end else begin
                if (saida_valid && saida_ready && q.size() > 0) begin
                    e = q.pop_front();
                    if (!cnt_clr) begin
                        if (e.c) cnt_c++;
                        if (e.du) cnt_d++;
                    end
                end
                if (cnt_clr) begin
                    cnt_c = 0;
                    cnt_d = 0;
                end
                if (entrada_valid && entrada_ready) begin
                    model(entrada, e.d, e.c, e.du);
                    q.push_back(e);
                end
            end
        end
    end

    task automatic push(input logic [IN_W-1:0] w);
        int g;
        g = 0;
        entrada       = w;
        entrada_valid = 1'b1;
        @(negedge clk);
        while (!entrada_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (!entrada_ready) chk("push_timeout", 1, 0);
        @(posedge clk);
        #1;
        entrada_valid = 1'b0;
        $display("[TB] sent %h", w);
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (q.size() != 0 && g < 50) begin
            @(posedge clk);
            #1;
            g++;
        end
        chk("drain_timeout", q.size(), 0);
    endtask

    task automatic wait_valid();
        int g;
        g = 0;
        while (!saida_valid && g < 20) begin
            @(posedge clk);
            #1;
            g++;
        end
        chk("wait_valid_timeout", saida_valid, 1);
    endtask

    initial begin
        logic [K-1:0] d;
        logic c, du;

        // Model pinned by hand-decoded words
`ifdef HAMMING_SECDED_EN
        model(16'h0003, d, c, du);
        chk("model_0003_d", d, 11'h000); chk("model_0003_c", c, 0); chk("model_0003_du", du, 1);
        model(16'h8000, d, c, du);
        chk("model_8000_d", d, 11'h000); chk("model_8000_c", c, 1); chk("model_8000_du", du, 0);
        model(16'hFFFE, d, c, du);
        chk("model_FFFE_d", d, 11'h7FF); chk("model_FFFE_c", c, 1);
`else
        model(15'h7FFF, d, c, du);
        chk("model_7FFF_d", d, 11'h7FF); chk("model_7FFF_c", c, 0);
        model(15'h0020, d, c, du);
        chk("model_0020_d", d, 11'h000); chk("model_0020_c", c, 1);
        model(15'h7FFE, d, c, du);
        chk("model_7FFE_d", d, 11'h7FF); chk("model_7FFE_c", c, 1);
`endif

        repeat (3) @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;
        chk("reset_saida_valid", saida_valid, 0);
        chk("reset_saida", saida, 0);
        chk("reset_erro_corrigido", erro_corrigido, 0);
        chk("reset_erro_duplo", erro_duplo, 0);
        chk("reset_cnt_corrigido", cnt_corrigido, 0);
        chk("reset_entrada_ready", entrada_ready, 1);

        // Latency: result visible after the second rising edge
        entrada       = CLEAN;
        entrada_valid = 1'b1;
        @(posedge clk);
        #1;
        entrada_valid = 1'b0;
        chk("latency_after_1_edge", saida_valid, 0);
        @(posedge clk);
        #1;
        chk("latency_after_2_edges", saida_valid, 1);
        chk("clean_saida", saida, 11'h7FF);
        chk("clean_erro_corrigido", erro_corrigido, 0);
        drain();

        push(ERR_A);
        push(ERR_B);
        drain();
        chk("two_errors_cnt", cnt_corrigido, 2);

`ifdef HAMMING_SECDED_EN
        push(16'h0003);
        push(16'h8000);
        drain();
        chk("secded_cnt_duplo", cnt_duplo, 1);
        chk("secded_cnt_corrigido", cnt_corrigido, 3);
`endif

        // Every single-bit flip of the all-zero and all-one codewords, back to back
        for (int i = 0; i < N; i++) push(IN_W'(1) << i);
        for (int i = 0; i < N; i++) push(CLEAN ^ (IN_W'(1) << i));
        drain();

        // Stall: pipe holds two words, input blocks, output holds
        saida_ready = 1'b0;
        push(CLEAN);
        push(ERR_A);
        entrada       = ERR_B;
        entrada_valid = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
            chk("stall_entrada_ready", entrada_ready, 0);
            chk("stall_saida_valid", saida_valid, 1);
            chk("stall_saida", saida, 11'h7FF);
        end
        saida_ready = 1'b1;
        push(ERR_B);
        push(IN_W'(1) << 14);
        drain();

        // Saturation on the 2-bit instance, then clear colliding with an error word
        for (int i = 0; i < 5; i++) push(ERR_A);
        drain();
        chk("sat_cnt_w2", cnt_corrigido_b, 3);
        push(ERR_A);
        wait_valid();
        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        chk("clr_priority_cnt", cnt_corrigido, 0);
        chk("clr_priority_cnt_w2", cnt_corrigido_b, 0);

        // Reset with two words in flight
        push(ERR_A);
        drain();
        saida_ready = 1'b0;
        push(CLEAN);
        push(ERR_B);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("inflight_rst_saida_valid", saida_valid, 0);
        chk("inflight_rst_cnt", cnt_corrigido, 0);
        chk("inflight_rst_cnt_w2", cnt_corrigido_b, 0);
        chk("inflight_rst_entrada_ready", entrada_ready, 1);
        saida_ready = 1'b1;
        push(ERR_B);
        @(posedge clk);
        #1;
        chk("post_rst_valid", saida_valid, 1);
        chk("post_rst_saida", saida, 11'h7FF);
        chk("post_rst_erro_corrigido", erro_corrigido, 1);
        drain();

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        fails++;
        $display("FAIL global_timeout: simulation did not complete");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
